// File: rtl/lsu_subword_adapter.sv
// Sub-word load/store adapter in front of a word-only cache controller.
// Sub-word stores are done as read-modify-write; loads are extracted and extended.
module lsu_subword_adapter #(
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        WE,
  output logic        RREQ,
  output logic [31:0] ADDR,
  output logic [31:0] DIN,
  input  logic [31:0] DOUT,
  input  logic        RDY
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_MERGE,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        ctl_idle_q, ctl_idle_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, we_d;
  logic        rreq_q, rreq_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] buf_q, buf_d;
  logic        op_we_q, op_we_d;
  logic [1:0]  op_size_q, op_size_d;
  logic        op_uns_q, op_uns_d;
  logic [1:0]  op_lo_q, op_lo_d;
  logic [15:0] op_wdata_q, op_wdata_d;

  logic        req_bad;
  logic [1:0]  req_size;
  logic [1:0]  req_lo;

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  lo,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  lo,
    input logic [15:0] d
  );
    logic [31:0] m;
    m = w;
    if (sz == 2'b00)
      m[{lo, 3'b000} +: 8] = d[7:0];
    else if (lo[1])
      m[31:16] = d;
    else
      m[15:0] = d;
    return m;
  endfunction

  // Illegal size degrades to a word access when errors are disabled.
  always_comb begin
    req_bad = (REQ_SIZE == 2'b11)
            | ((REQ_SIZE == 2'b01) & REQ_ADDR[0])
            | ((REQ_SIZE == 2'b10) & (|REQ_ADDR[1:0]));
    req_size = (REQ_SIZE == 2'b11) ? 2'b10 : REQ_SIZE;
    unique case (req_size)
      2'b00:   req_lo = REQ_ADDR[1:0];
      2'b01:   req_lo = {REQ_ADDR[1], 1'b0};
      default: req_lo = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ctl_idle_d = RDY ? 1'b1 : ctl_idle_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    we_d       = 1'b0;
    rreq_d     = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    buf_d      = buf_q;
    op_we_d    = op_we_q;
    op_size_d  = op_size_q;
    op_uns_d   = op_uns_q;
    op_lo_d    = op_lo_q;
    op_wdata_d = op_wdata_q;
    unique case (state_q)
      S_SYNC: begin
        if (ctl_idle_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (REQ) begin
          op_we_d    = REQ_WE;
          op_size_d  = req_size;
          op_uns_d   = REQ_UNSIGNED;
          op_lo_d    = req_lo;
          op_wdata_d = REQ_WDATA[15:0];
          addr_d     = {REQ_ADDR[31:2], 2'b00};
          if (req_bad && MISALIGN_ERR) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = S_FIN;
          end else if (REQ_WE && req_size == 2'b10) begin
            din_d   = REQ_WDATA;
            state_d = S_WR_ISSUE;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE: begin
        if (ctl_idle_q) begin
          rreq_d     = 1'b1;
          ctl_idle_d = 1'b0;
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (RDY) begin
          buf_d = DOUT;
          if (op_we_q) begin
            state_d = S_MERGE;
          end else begin
            done_d  = 1'b1;
            rdata_d = extract(DOUT, op_size_q, op_lo_q, op_uns_q);
            state_d = S_FIN;
          end
        end
      end
      S_MERGE: begin
        din_d   = merge(buf_q, op_size_q, op_lo_q, op_wdata_q);
        state_d = S_WR_ISSUE;
      end
      S_WR_ISSUE: begin
        if (ctl_idle_q) begin
          we_d       = 1'b1;
          ctl_idle_d = 1'b0;
          state_d    = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (RDY) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_SYNC;
      ctl_idle_q <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'd0;
      we_q       <= 1'b0;
      rreq_q     <= 1'b0;
      addr_q     <= 32'd0;
      din_q      <= 32'd0;
      buf_q      <= 32'd0;
      op_we_q    <= 1'b0;
      op_size_q  <= 2'b00;
      op_uns_q   <= 1'b0;
      op_lo_q    <= 2'b00;
      op_wdata_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      ctl_idle_q <= ctl_idle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      rreq_q     <= rreq_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      buf_q      <= buf_d;
      op_we_q    <= op_we_d;
      op_size_q  <= op_size_d;
      op_uns_q   <= op_uns_d;
      op_lo_q    <= op_lo_d;
      op_wdata_q <= op_wdata_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign WE    = we_q;
  assign RREQ  = rreq_q;
  assign ADDR  = addr_q;
  assign DIN   = din_q;

endmodule

// File: tb/tb_lsu_subword_adapter.sv
// Bench for lsu_subword_adapter: directed requests against a small
// word-memory controller model, results checked through a scoreboard.
module tb_lsu_subword_adapter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ = 1'b0;
  logic        REQ_WE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_ADDR = 32'd0;
  logic [31:0] REQ_WDATA = 32'd0;
  logic        BUSY, DONE, ERR, WE, RREQ;
  logic [31:0] RDATA, ADDR, DIN;
  logic [31:0] DOUT = 32'd0;
  logic        RDY = 1'b0;

  lsu_subword_adapter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .WE(WE), .RREQ(RREQ), .ADDR(ADDR), .DIN(DIN),
    .DOUT(DOUT), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int nrreq = 0, nwe = 0, ndone = 0, nrdy = 0, viol = 0;
  logic [31:0] last_din = 32'd0;
  logic [31:0] mem [0:63];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          nr;
    int          nw;
  } exp_t;
  exp_t sbq[$];

  // Controller model: fixed 2-cycle response, one RDY after reset.
  initial begin : ctl_model
    int   lat;
    logic boot, kind_wr, prev;
    logic [31:0] pa, pd;
    lat = 0; boot = 1'b0; kind_wr = 1'b0; prev = 1'b0;
    pa = 32'd0; pd = 32'd0;
    forever begin
      @(posedge CLK);
      #1;
      RDY = 1'b0;
      if (DONE === 1'b1) ndone++;
      if (RST) begin
        lat = 3;
        boot = 1'b1;
        prev = 1'b0;
      end else begin
        if (RREQ === 1'b1 || WE === 1'b1) begin
          if (lat != 0 || prev || (RREQ === 1'b1 && WE === 1'b1)) viol++;
          if (RREQ === 1'b1) begin
            nrreq++;
            kind_wr = 1'b0;
          end else begin
            nwe++;
            kind_wr = 1'b1;
            pd = DIN;
            last_din = DIN;
          end
          pa = ADDR;
          lat = 2;
          boot = 1'b0;
        end else if (lat != 0) begin
          lat--;
          if (lat == 0) begin
            RDY = 1'b1;
            nrdy++;
            if (!boot) begin
              if (kind_wr) mem[pa[7:2]] = pd;
              else DOUT = mem[pa[7:2]];
            end
            boot = 1'b0;
          end
        end
        prev = (RREQ === 1'b1 || WE === 1'b1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b0) break;
    end
    chk(tag, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic issue(input string tag, input logic we,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd,
                       input int e_nr, input int e_nw);
    int br, bw, bd;
    exp_t e;
    wait_idle({tag, "_idle"});
    tick();
    br = nrreq; bw = nwe; bd = ndone;
    sbq.push_back('{err: e_err, rdata: e_rd, nr: e_nr, nw: e_nw});
    REQ = 1'b1; REQ_WE = we; REQ_SIZE = sz;
    REQ_UNSIGNED = uns; REQ_ADDR = a; REQ_WDATA = wd;
    tick();
    REQ = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) break;
    end
    chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
    e = sbq.pop_front();
    chk({tag, "_err"}, {31'd0, ERR}, {31'd0, e.err});
    if (!we || e_err) chk({tag, "_rdata"}, RDATA, e.rdata);
    chk({tag, "_addr"}, ADDR, {a[31:2], 2'b00});
    chk({tag, "_nrreq"}, nrreq - br, e.nr);
    chk({tag, "_nwe"}, nwe - bw, e.nw);
    chk({tag, "_ndone"}, ndone - bd, 1);
  endtask

  initial begin : stim
    int br, bw, bd, brdy;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h8040C0F1;
    repeat (3) tick();
    @(negedge CLK);
    chk("rst_ctl", {27'd0, BUSY, DONE, ERR, WE, RREQ}, 32'h10);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_addr", ADDR, 32'd0);
    chk("rst_din", DIN, 32'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("sync_busy", {31'd0, BUSY}, 32'd1);
    wait_idle("boot_idle");

    issue("lb",  1'b0, 2'b00, 1'b0, 32'h103, 0, 1'b0, 32'hFFFFFF80, 1, 0);
    issue("lbu", 1'b0, 2'b00, 1'b1, 32'h101, 0, 1'b0, 32'h000000C0, 1, 0);
    issue("lh",  1'b0, 2'b01, 1'b0, 32'h102, 0, 1'b0, 32'hFFFF8040, 1, 0);
    issue("lhu", 1'b0, 2'b01, 1'b1, 32'h100, 0, 1'b0, 32'h0000C0F1, 1, 0);
    issue("lw",  1'b0, 2'b10, 1'b0, 32'h100, 0, 1'b0, 32'h8040C0F1, 1, 0);

    mem[0] = 32'h11223344;
    issue("sb", 1'b1, 2'b00, 1'b0, 32'h102, 32'hAA, 1'b0, 0, 1, 1);
    chk("sb_din", last_din, 32'h11AA3344);
    issue("lw_sb", 1'b0, 2'b10, 1'b0, 32'h100, 0, 1'b0, 32'h11AA3344, 1, 0);

    issue("sw", 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 1'b0, 0, 0, 1);
    chk("sw_din", last_din, 32'hDEADBEEF);
    chk("sw_mem", mem[1], 32'hDEADBEEF);

    issue("sh_mis", 1'b1, 2'b01, 1'b0, 32'h101, 32'h1234, 1'b1, 0, 0, 0);
    issue("lw_mis", 1'b0, 2'b10, 1'b0, 32'h102, 0, 1'b1, 0, 0, 0);
    issue("sz11",   1'b0, 2'b11, 1'b0, 32'h100, 0, 1'b1, 0, 0, 0);

    // REQ held through an RMW, then re-pulsed while still busy.
    wait_idle("hold_idle");
    tick();
    br = nrreq; bw = nwe; bd = ndone;
    REQ = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b01;
    REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h100; REQ_WDATA = 32'h5A5A;
    repeat (5) tick();
    REQ = 1'b0;
    tick();
    REQ = 1'b1;
    tick();
    REQ = 1'b0;
    repeat (30) tick();
    chk("hold_ndone", ndone - bd, 1);
    chk("hold_nrreq", nrreq - br, 1);
    chk("hold_nwe", nwe - bw, 1);
    chk("hold_din", last_din, 32'h11AA5A5A);
    issue("lw_hold", 1'b0, 2'b10, 1'b0, 32'h100, 0, 1'b0, 32'h11AA5A5A, 1, 0);

    // Reset while the read is outstanding.
    wait_idle("rst_idle");
    tick();
    br = nrreq; bd = ndone;
    REQ = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_ADDR = 32'h104;
    tick();
    REQ = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (nrreq != br) break;
    end
    chk("rst_rreq_seen", nrreq - br, 1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    brdy = nrdy;
    @(negedge CLK);
    chk("rst_busy", {31'd0, BUSY}, 32'd1);
    wait_idle("rst_resync");
    chk("rst_rdy_first", {31'd0, nrdy > brdy}, 32'd1);
    chk("rst_no_done", ndone - bd, 0);
    issue("lw_after", 1'b0, 2'b10, 1'b0, 32'h104, 0, 1'b0, 32'hDEADBEEF, 1, 0);

    repeat (5) tick();
    chk("protocol", viol, 0);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
